// File: rtl/mc_pkg.sv
// Shared definitions for the sequential AES MixColumns unit: GF(2^8) reduction constant,
// byte/column index helpers for the 128-bit state ordering, and the control FSM encoding.
package mc_pkg;

  localparam logic [7:0] AES_POLY_RED = 8'h1b;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } mc_state_e;

  // Byte 0 sits in the top byte of the state, byte 15 in the bottom byte.
  function automatic logic [6:0] byte_lsb(logic [3:0] idx);
    return {~idx, 3'b000};
  endfunction

  function automatic logic [6:0] col_lsb(logic [1:0] idx);
    return {~idx, 5'b00000};
  endfunction

  function automatic logic [31:0] get_col(logic [127:0] s, logic [1:0] idx);
    return s[col_lsb(idx) +: 32];
  endfunction

  function automatic logic [127:0] set_col(logic [127:0] s, logic [1:0] idx, logic [31:0] col);
    logic [127:0] r;
    r = s;
    r[col_lsb(idx) +: 32] = col;
    return r;
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY_RED : 8'h00);
  endfunction

endpackage

// File: rtl/mc_col_fwdinv.sv
// Single-column MixColumns. The inverse transform is a cheap pre-step folded in front of
// the forward matrix, so one datapath serves both modes.
module mc_col_fwdinv
  import mc_pkg::*;
(
  input  logic [7:0] in0,
  input  logic [7:0] in1,
  input  logic [7:0] in2,
  input  logic [7:0] in3,
  input  logic       inv,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3
);

  logic [7:0] u, v;
  logic [7:0] a0, a1, a2, a3;

  always_comb begin
    u  = inv ? xtime(xtime(in0 ^ in2)) : 8'h00;
    v  = inv ? xtime(xtime(in1 ^ in3)) : 8'h00;
    a0 = in0 ^ u;
    a1 = in1 ^ v;
    a2 = in2 ^ u;
    a3 = in3 ^ v;
    // 3x = 2x ^ x
    out0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    out1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    out2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    out3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
  end

endmodule

// File: rtl/mc_seq_umsk.sv
// Sequential unmasked MixColumns over a 128-bit state, NCOLS columns per cycle, with
// valid/ready handshakes on both sides and per-transaction forward/inverse selection.
module mc_seq_umsk
  import mc_pkg::*;
#(
  parameter int unsigned NCOLS  = 1,
  parameter bit          INV_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(NCOLS == 1 || NCOLS == 2 || NCOLS == 4)) begin : g_bad_ncols
    $error("mc_seq_umsk: NCOLS must be 1, 2 or 4");
  end

  localparam int unsigned NGROUPS = 4 / NCOLS;
  localparam int unsigned CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGROUPS - 1);

  mc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [127:0]     data_q, data_d;
  logic             mode_q, mode_d;

  logic [1:0]  col_idx [NCOLS];
  logic [31:0] col_in  [NCOLS];
  logic [31:0] col_out [NCOLS];

  for (genvar g = 0; g < NCOLS; g++) begin : g_col
    assign col_idx[g] = 2'(32'(cnt_q) * NCOLS + 32'(g));
    assign col_in[g]  = get_col(data_q, col_idx[g]);

    mc_col_fwdinv u_col (
      .in0  (col_in[g][31:24]),
      .in1  (col_in[g][23:16]),
      .in2  (col_in[g][15:8]),
      .in3  (col_in[g][7:0]),
      .inv  (mode_q),
      .out0 (col_out[g][31:24]),
      .out1 (col_out[g][23:16]),
      .out2 (col_out[g][15:8]),
      .out3 (col_out[g][7:0])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    mode_d    = mode_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_d  = in_state;
          // Mode is forced to forward when inverse support is not built.
          mode_d  = in_inv & INV_EN;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        for (int g = 0; g < NCOLS; g++) begin
          data_d = set_col(data_d, col_idx[g], col_out[g]);
        end
        if (cnt_q == CNT_LAST) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      data_q  <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
    end
  end

  assign out_state = data_q;

endmodule

// File: tb/tb_mc_seq_umsk.sv
// Bench for mc_seq_umsk: four builds (NCOLS 1/2/4, and NCOLS 1 without inverse support)
// checked against a matrix-multiply GF(2^8) reference model.
module tb_mc_seq_umsk;

  localparam logic [127:0] FIPS_IN  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] FIPS_OUT = 128'h046681e5e0cb199a48f8d37a2806264c;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [4];
  logic         in_ready  [4];
  logic         in_inv    [4];
  logic [127:0] in_state  [4];
  logic         out_valid [4];
  logic         out_ready [4];
  logic [127:0] out_state [4];

  int checks   = 0;
  int failures = 0;

  for (genvar d = 0; d < 4; d++) begin : g_dut
    localparam int unsigned NC = (d == 1) ? 2 : (d == 2) ? 4 : 1;
    localparam bit          IE = (d != 3);
    mc_seq_umsk #(.NCOLS(NC), .INV_EN(IE)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[d]),
      .in_ready  (in_ready[d]),
      .in_inv    (in_inv[d]),
      .in_state  (in_state[d]),
      .out_valid (out_valid[d]),
      .out_ready (out_ready[d]),
      .out_state (out_state[d])
    );
  end

  function automatic int exp_lat(int d);
    return (d == 1) ? 2 : (d == 2) ? 1 : 4;
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(logic inv, int k);
    case (k)
      0:       return inv ? 8'h0e : 8'h02;
      1:       return inv ? 8'h0b : 8'h03;
      2:       return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  // Circulant matrix times each column, bytes emitted in state order.
  function automatic logic [127:0] mc_model(logic [127:0] s, logic inv);
    logic [127:0] r;
    logic [7:0]   acc, b;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++) begin
          b   = 8'(s >> (8 * (15 - (4 * c + k))));
          acc = acc ^ gmul(coef(inv, (k - row) & 3), b);
        end
        r = (r << 8) | 128'(acc);
      end
    end
    return r;
  endfunction

  task automatic txn(input int d, input logic [127:0] s, input logic inv,
                     output logic [127:0] res, output int lat);
    @(negedge clk);
    checks++;
    if (in_ready[d] !== 1'b1) begin
      failures++;
      $display("FAIL txn_in_ready dut=%0d got=%b want=1", d, in_ready[d]);
    end
    in_valid[d] = 1'b1;
    in_state[d] = s;
    in_inv[d]   = inv;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    in_state[d] = {$urandom, $urandom, $urandom, $urandom};
    in_inv[d]   = 1'($urandom_range(0, 1));
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid[d] && lat < 20);
    checks++;
    if (out_valid[d] !== 1'b1) begin
      failures++;
      $display("FAIL txn_timeout dut=%0d out_valid=%b want=1", d, out_valid[d]);
      res = '0;
      return;
    end
    res = out_state[d];
    out_ready[d] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[d] = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
      failures++;
      $display("FAIL txn_return_idle dut=%0d in_ready=%b out_valid=%b want 1/0",
               d, in_ready[d], out_valid[d]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      checks++;
      if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0 || out_state[d] !== 128'h0) begin
        failures++;
        $display("FAIL reset_state dut=%0d in_ready=%b out_valid=%b out_state=%h want 1/0/0",
                 d, in_ready[d], out_valid[d], out_state[d]);
      end
    end
  endtask

  task automatic test_fips_fwd();
    logic [127:0] res;
    int lat;
    for (int d = 0; d < 3; d++) begin
      txn(d, FIPS_IN, 1'b0, res, lat);
      checks++;
      if (res !== FIPS_OUT) begin
        failures++;
        $display("FAIL fips_fwd dut=%0d got=%h want=%h", d, res, FIPS_OUT);
      end
      checks++;
      if (lat !== exp_lat(d)) begin
        failures++;
        $display("FAIL fips_latency dut=%0d got=%0d want=%0d", d, lat, exp_lat(d));
      end
    end
  endtask

  task automatic test_inverse();
    logic [127:0] res;
    int lat;
    for (int d = 0; d < 3; d++) begin
      txn(d, FIPS_OUT, 1'b1, res, lat);
      checks++;
      if (res !== FIPS_IN) begin
        failures++;
        $display("FAIL fips_inv dut=%0d got=%h want=%h", d, res, FIPS_IN);
      end
      txn(d, {4{32'h8e4da1bc}}, 1'b1, res, lat);
      checks++;
      if (res !== {4{32'hdb135345}}) begin
        failures++;
        $display("FAIL col_inv dut=%0d got=%h want=%h", d, res, {4{32'hdb135345}});
      end
    end
  endtask

  task automatic test_fixed();
    logic [127:0] res;
    logic [127:0] mixed_in, mixed_out;
    int lat;
    for (int m = 0; m < 2; m++) begin
      txn(1, {16{8'hc6}}, 1'(m), res, lat);
      checks++;
      if (res !== {16{8'hc6}}) begin
        failures++;
        $display("FAIL fixed_c6 mode=%0d got=%h want=%h", m, res, {16{8'hc6}});
      end
      txn(1, {16{8'h01}}, 1'(m), res, lat);
      checks++;
      if (res !== {16{8'h01}}) begin
        failures++;
        $display("FAIL fixed_01 mode=%0d got=%h want=%h", m, res, {16{8'h01}});
      end
    end
    mixed_in  = {32'hf20a225c, 32'hdb135345, 32'hf20a225c, 32'hc6c6c6c6};
    mixed_out = {32'h9fdc589d, 32'h8e4da1bc, 32'h9fdc589d, 32'hc6c6c6c6};
    txn(1, mixed_in, 1'b0, res, lat);
    checks++;
    if (res !== mixed_out) begin
      failures++;
      $display("FAIL two_col_mixed got=%h want=%h", res, mixed_out);
    end
  endtask

  task automatic test_random();
    logic [127:0] s, res, exp;
    logic inv;
    int d, lat;
    for (int n = 0; n < 24; n++) begin
      d   = int'($urandom_range(0, 3));
      inv = 1'($urandom_range(0, 1));
      s   = {$urandom, $urandom, $urandom, $urandom};
      exp = mc_model(s, inv && (d != 3));
      txn(d, s, inv, res, lat);
      checks++;
      if (res !== exp || lat !== exp_lat(d)) begin
        failures++;
        $display("FAIL random dut=%0d inv=%b in=%h got=%h lat=%0d want=%h lat=%0d",
                 d, inv, s, res, lat, exp, exp_lat(d));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s, exp;
    int lat;
    s   = {$urandom, $urandom, $urandom, $urandom};
    exp = mc_model(s, 1'b1);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = s;
    in_inv[0]   = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end while (!out_valid[0] && lat < 20);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      in_state[0] = {$urandom, $urandom, $urandom, $urandom};
      in_inv[0]   = 1'($urandom_range(0, 1));
      checks++;
      if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || out_state[0] !== exp) begin
        failures++;
        $display("FAIL backpressure_hold cyc=%0d out_valid=%b in_ready=%b out=%h want 1/0/%h",
                 i, out_valid[0], in_ready[0], out_state[0], exp);
      end
    end
    @(negedge clk);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    out_ready[0] = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
      failures++;
      $display("FAIL backpressure_release in_ready=%b out_valid=%b want 1/0",
               in_ready[0], out_valid[0]);
    end
  endtask

  task automatic test_reset_mid_busy();
    logic [127:0] res;
    int lat;
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_state[0] = FIPS_IN;
    in_inv[0]   = 1'b0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid[0] !== 1'b0 || out_state[0] !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid_busy_async out_valid=%b out_state=%h want 0/0",
               out_valid[0], out_state[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_state[0] !== 128'h0) begin
      failures++;
      $display("FAIL reset_mid_busy_release in_ready=%b out_valid=%b out=%h want 1/0/0",
               in_ready[0], out_valid[0], out_state[0]);
    end
    txn(0, FIPS_IN, 1'b0, res, lat);
    checks++;
    if (res !== FIPS_OUT) begin
      failures++;
      $display("FAIL reset_mid_busy_next got=%h want=%h", res, FIPS_OUT);
    end
  endtask

  task automatic test_no_inv();
    logic [127:0] res;
    int lat;
    txn(3, FIPS_IN, 1'b1, res, lat);
    checks++;
    if (res !== FIPS_OUT) begin
      failures++;
      $display("FAIL no_inv_build got=%h want=%h", res, FIPS_OUT);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 4; d++) begin
      in_valid[d]  = 1'b0;
      in_inv[d]    = 1'b0;
      in_state[d]  = '0;
      out_ready[d] = 1'b0;
    end
    test_reset();
    test_fips_fwd();
    test_inverse();
    test_fixed();
    test_backpressure();
    test_reset_mid_busy();
    test_no_inv();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
